ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single RAM transaction port (txs/txe/re/we/addr/wd/out/err) between N_REQ
//  requesters: CPU fetch/stack port, DMA, interrupt-vector loader. Round-robin arbitration.
//  Whole transactions are granted: a grant is held until the owner drops txs and the RAM drops txe.
//  Optional watchdog ends a transaction that the RAM never completes.
// PARAMETERS
//  N_REQ    2   number of requesters (>=2); requester i uses slice i of every packed vector
//  ADDR_W   64  RAM address width
//  DATA_W   32  RAM data width
//  TIMEOUT  0   cycles in BUSY without ram_txe before forced error; 0 = watchdog disabled
// PORTS
//  clk       in   1              clock, all state on posedge
//  rst_n     in   1              asynchronous active-low reset
//  req_txs   in   N_REQ          requester holds high for whole transaction
//  req_re    in   N_REQ          read strobe
//  req_we    in   N_REQ          write strobe
//  req_addr  in   N_REQ*ADDR_W   transaction address
//  req_wd    in   N_REQ*DATA_W   write data
//  req_txe   out  N_REQ          transaction end, only granted slice may be 1
//  req_err   out  N_REQ          error, only granted slice may be 1
//  req_out   out  DATA_W         read data, broadcast (= ram_out)
//  grant     out  N_REQ          one-hot owner while BUSY, else 0
//  ram_txs   out  1 ; ram_re out 1 ; ram_we out 1 ; ram_addr out ADDR_W ; ram_wd out DATA_W
//  ram_txe   in   1 ; ram_err in 1 ; ram_out in DATA_W
// BEHAVIOUR
//  State: st in {IDLE,BUSY,RELEASE}, gnt (owner index), ptr (rr pointer), tmr, to_flag.
//  Reset (async, rst_n=0): st=IDLE, gnt=0, ptr=0, tmr=0, to_flag=0 => every output 0.
//  IDLE: if any req_txs: gnt<=first i scanning ptr,ptr+1,..(mod N_REQ) with req_txs[i]=1;
//   st<=BUSY; tmr<=0. No request: stay. Arbitration latency = 1 cycle (txs edge -> ram_txs).
//  BUSY (combinational forwarding of owner g):
//   ram_txs=req_txs[g], ram_re=req_re[g], ram_we=req_we[g], ram_addr/ram_wd=slice g;
//   req_txe[g]=ram_txe|to_flag, req_err[g]=ram_err|to_flag; all other slices 0.
//   Owner may change re/we/addr/wd mid-transaction; forwarded same cycle.
//   Watchdog (TIMEOUT>0): tmr++ each BUSY cycle while ram_txe=0; tmr==TIMEOUT-1 -> to_flag<=1;
//   to_flag holds until leaving BUSY. ram_txe=1 freezes tmr.
//   req_txs[g]=0 -> st<=RELEASE (also covers abort before ram_txe).
//  RELEASE: all ram_* outputs 0, grant=0, req_txe/err=0. When ram_txe=0: st<=IDLE,
//   ptr<=(gnt+1) mod N_REQ, to_flag<=0. ram_txe stuck high keeps RELEASE (no new grant).
//  Idle outputs: ram_* = 0, grant = 0, req_txe/req_err = 0.
//  Fairness: a waiting requester is granted within N_REQ-1 other transactions.
//  Non-owners see req_txe=0, so a requester checking !txe before starting may start anytime.
//  Simultaneous requests in IDLE: lowest index at/after ptr wins; others wait, untouched.
//  Owner drops txs same cycle another raises: RELEASE->IDLE->arbitrate (>=2 dead cycles).
//  Reset mid-BUSY: outputs drop to 0 immediately (ram_txs falls asynchronously).
//  Width rules: ptr/gnt are $clog2(N_REQ) bits, wrap mod N_REQ; tmr sized for TIMEOUT.
// TESTING
//  1 N=2, req0 read addr 0x10, RAM txe after 3 cycles, out=0xDEADBEEF -> ram_txs 1 cycle
//    after req_txs[0], ram_addr=0x10, req_txe=2'b01, req_out=0xDEADBEEF, req1 slices 0.
//  2 req0 and req1 raise txs same edge after reset (ptr=0) -> grant=01 first; after req0
//    release and txe low, grant=10; ptr ends 0.
//  3 req0 re-requests back-to-back, req1 waiting -> order 0,1,0,1 (never 0,0 while 1 waits).
//  4 TIMEOUT=8, RAM never asserts txe -> req_txe[g]=req_err[g]=1 on 8th BUSY cycle; owner
//    drops txs -> RELEASE -> IDLE, to_flag cleared, next request served normally.
//  5 ram_err=1 with txe during req1 write (wd=0x12345678) -> req_err=2'b10, ram_we=1,
//    ram_wd=0x12345678; req0 sees err=0.
//  6 rst_n low mid-BUSY -> ram_txs, grant, req_txe drop at once; after release ptr=0, st=IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single RAM transaction port. Whole transactions are granted
// and forwarded combinationally to the owner, with an optional completion watchdog.
module ram_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_txs,
    input  logic [N_REQ-1:0]          req_re,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wd,
    output logic [N_REQ-1:0]          req_txe,
    output logic [N_REQ-1:0]          req_err,
    output logic [DATA_W-1:0]         req_out,
    output logic [N_REQ-1:0]          grant,
    output logic                      ram_txs,
    output logic                      ram_re,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wd,
    input  logic                      ram_txe,
    input  logic                      ram_err,
    input  logic [DATA_W-1:0]         ram_out
);
    localparam int GW = $clog2(N_REQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Flag is registered, so it is raised one count early to show on the TIMEOUT-th busy cycle.
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);
    localparam logic [GW-1:0] LAST_REQ = GW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} st_t;

    st_t           st;
    logic [GW-1:0] gnt;
    logic [GW-1:0] ptr;
    logic [TW-1:0] tmr;
    logic          to_flag;
    logic [GW-1:0] pick;

    logic [ADDR_W-1:0] addr_a [N_REQ];
    logic [DATA_W-1:0] wd_a   [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign wd_a[i]   = req_wd[i*DATA_W +: DATA_W];
    end

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return GW'(s);
    endfunction

    // Scan from the far end back so the requester closest to ptr wins.
    always_comb begin
        pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_txs[rr_idx(ptr, i)]) pick = rr_idx(ptr, i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            gnt     <= '0;
            ptr     <= '0;
            tmr     <= '0;
            to_flag <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (|req_txs) begin
                        gnt <= pick;
                        st  <= BUSY;
                        tmr <= '0;
                    end
                end
                BUSY: begin
                    if (TIMEOUT > 0 && !ram_txe && !to_flag) begin
                        tmr <= tmr + TW'(1);
                        if (tmr == TMR_LAST) to_flag <= 1'b1;
                    end
                    if (!req_txs[gnt]) st <= RELEASE;
                end
                RELEASE: begin
                    // A RAM still holding txe keeps the port closed to everyone.
                    if (!ram_txe) begin
                        st      <= IDLE;
                        ptr     <= (gnt == LAST_REQ) ? '0 : gnt + GW'(1);
                        to_flag <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_txs  = 1'b0;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wd   = '0;
        req_txe  = '0;
        req_err  = '0;
        grant    = '0;
        if (st == BUSY) begin
            ram_txs      = req_txs[gnt];
            ram_re       = req_re[gnt];
            ram_we       = req_we[gnt];
            ram_addr     = addr_a[gnt];
            ram_wd       = wd_a[gnt];
            req_txe[gnt] = ram_txe | to_flag;
            req_err[gnt] = ram_err | to_flag;
            grant[gnt]   = 1'b1;
        end
    end

    assign req_out = ram_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: two requesters, a latency-configurable RAM model, watchdog of 8.
module tb_ram_arbiter;
    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_txs, req_re, req_we, req_txe, req_err, grant;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wd;
    logic [DW-1:0] req_out, ram_wd, ram_out;
    logic [AW-1:0] ram_addr;
    logic          ram_txs, ram_re, ram_we, ram_txe, ram_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int ram_lat    = 3;
    bit ram_hang   = 1'b0;
    bit ram_err_en = 1'b0;
    int ram_cnt    = 0;

    ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_txs(req_txs), .req_re(req_re), .req_we(req_we),
        .req_addr(req_addr), .req_wd(req_wd),
        .req_txe(req_txe), .req_err(req_err), .req_out(req_out), .grant(grant),
        .ram_txs(ram_txs), .ram_re(ram_re), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wd(ram_wd),
        .ram_txe(ram_txe), .ram_err(ram_err), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // RAM model: raises txe ram_lat cycles into a transaction, holds it until txs drops.
    initial begin
        ram_txe = 1'b0;
        ram_err = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!ram_txs) begin
                ram_txe = 1'b0;
                ram_err = 1'b0;
                ram_cnt = 0;
            end else if (!ram_hang && !ram_txe) begin
                ram_cnt++;
                if (ram_cnt >= ram_lat) begin
                    ram_txe = 1'b1;
                    ram_err = ram_err_en;
                end
            end
        end
    end

    task automatic start(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req_txs[i] = 1'b1;
        req_re[i]  = !we;
        req_we[i]  = we;
        req_addr[i*AW +: AW] = a;
        req_wd[i*DW +: DW]   = d;
    endtask

    task automatic stop(input int i);
        @(negedge clk);
        req_txs[i] = 1'b0;
        req_re[i]  = 1'b0;
        req_we[i]  = 1'b0;
    endtask

    task automatic wait_txe(output bit ok, output int ncyc);
        ok = 1'b0;
        ncyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (req_txe != '0) begin
                ok = 1'b1;
                ncyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({ram_txs, ram_re, ram_we, grant, req_txe, req_err} !== '0 || ram_addr !== '0 || ram_wd !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got txs=%b re=%b we=%b grant=%b txe=%b err=%b addr=%h wd=%h, want all 0",
                     ram_txs, ram_re, ram_we, grant, req_txe, req_err, ram_addr, ram_wd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        n_cmp++;
        if (grant !== '0 || ram_txs !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_req: got grant=%b txs=%b, want 00/0", grant, ram_txs);
        end
    endtask

    task automatic test_read();
        bit ok;
        int nc;
        exp_t e;
        ram_lat = 3;
        ram_out = 32'hDEADBEEF;
        exp_q.push_back('{idx: 0, data: 32'hDEADBEEF, err: 1'b0});
        start(0, 1'b0, 64'h10, 32'h0);
        #1;
        n_cmp++;
        if (ram_txs !== 1'b0) begin
            n_bad++;
            $display("FAIL arb_latency: ram_txs=%b same cycle as req_txs, want 0", ram_txs);
        end
        @(posedge clk);
        #2;
        n_cmp++;
        if (ram_txs !== 1'b1 || grant !== 2'b01 || ram_addr !== 64'h10 || ram_re !== 1'b1 || ram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL read_grant: got txs=%b grant=%b addr=%h re=%b we=%b, want 1/01/10/1/0",
                     ram_txs, grant, ram_addr, ram_re, ram_we);
        end
        @(negedge clk);
        req_addr[0 +: AW] = 64'h18;
        #1;
        n_cmp++;
        if (ram_addr !== 64'h18) begin
            n_bad++;
            $display("FAIL fwd_addr_change: got addr=%h, want 18", ram_addr);
        end
        wait_txe(ok, nc);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL read_txe_wait: no req_txe within 40 cycles, want txe");
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (req_txe !== (2'b01 << e.idx) || req_out !== e.data || req_err !== '0) begin
            n_bad++;
            $display("FAIL read_result: got txe=%b out=%h err=%b, want %b/%h/00",
                     req_txe, req_out, req_err, 2'b01 << e.idx, e.data);
        end
        stop(0);
        @(posedge clk);
        #2;
        n_cmp++;
        if (ram_txs !== 1'b0 || grant !== '0 || req_txe !== '0) begin
            n_bad++;
            $display("FAIL release_outputs: got txs=%b grant=%b txe=%b, want 0/00/00", ram_txs, grant, req_txe);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_simultaneous();
        bit ok;
        int nc;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{idx: 0, data: 32'hA0A0_0001, err: 1'b0});
        exp_q.push_back('{idx: 1, data: 32'hB1B1_0002, err: 1'b0});
        @(negedge clk);
        req_txs = 2'b11;
        req_re  = 2'b11;
        req_addr = {64'h200, 64'h100};
        ram_out = 32'hA0A0_0001;
        for (int k = 0; k < 2; k++) begin
            wait_txe(ok, nc);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL simul_wait%0d: no req_txe within 40 cycles, want txe", k);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== (2'b01 << e.idx) || req_txe !== (2'b01 << e.idx) || req_out !== e.data) begin
                n_bad++;
                $display("FAIL simul_order%0d: got grant=%b txe=%b out=%h, want %b/%b/%h",
                         k, grant, req_txe, req_out, 2'b01 << e.idx, 2'b01 << e.idx, e.data);
            end
            stop(k);
            ram_out = 32'hB1B1_0002;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int nc;
        int g;
        exp_t e;
        for (int k = 0; k < 4; k++) exp_q.push_back('{idx: k % 2, data: 32'h0, err: 1'b0});
        @(negedge clk);
        req_txs = 2'b11;
        req_re  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_txe(ok, nc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || grant !== (2'b01 << e.idx)) begin
                n_bad++;
                $display("FAIL b2b_order%0d: got grant=%b ok=%0d, want %b", k, grant, ok, 2'b01 << e.idx);
            end
            g = grant[1] ? 1 : 0;
            stop(g);
            if (k < 2) begin
                @(negedge clk);
                req_txs[g] = 1'b1;
                req_re[g]  = 1'b1;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write_err();
        bit ok;
        int nc;
        exp_t e;
        ram_err_en = 1'b1;
        exp_q.push_back('{idx: 1, data: 32'h0, err: 1'b1});
        start(1, 1'b1, 64'h20, 32'h12345678);
        @(posedge clk);
        #2;
        n_cmp++;
        if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_wd !== 32'h12345678 || grant !== 2'b10 || ram_addr !== 64'h20) begin
            n_bad++;
            $display("FAIL write_fwd: got we=%b re=%b wd=%h grant=%b addr=%h, want 1/0/12345678/10/20",
                     ram_we, ram_re, ram_wd, grant, ram_addr);
        end
        wait_txe(ok, nc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || req_txe !== (2'b01 << e.idx) || req_err !== ({1'b0, e.err} << e.idx)) begin
            n_bad++;
            $display("FAIL write_err: got ok=%0d txe=%b err=%b, want 10/10", ok, req_txe, req_err);
        end
        ram_err_en = 1'b0;
        stop(1);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int nc;
        int first;
        first = 0;
        ram_hang = 1'b1;
        start(0, 1'b0, 64'h30, 32'h0);
        for (int c = 1; c <= 12 && first == 0; c++) begin
            @(posedge clk);
            #2;
            if (req_txe != '0) first = c;
        end
        n_cmp++;
        if (first !== 8) begin
            n_bad++;
            $display("FAIL timeout_cycle: txe on busy cycle %0d, want 8", first);
        end
        n_cmp++;
        if (req_txe !== 2'b01 || req_err !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_flags: got txe=%b err=%b, want 01/01", req_txe, req_err);
        end
        stop(0);
        ram_hang = 1'b0;
        repeat (2) @(posedge clk);
        start(1, 1'b0, 64'h40, 32'h0);
        wait_txe(ok, nc);
        n_cmp++;
        if (!ok || nc !== 4 || req_err !== '0 || req_txe !== 2'b10) begin
            n_bad++;
            $display("FAIL post_timeout: got ok=%0d cycle=%0d txe=%b err=%b, want 1/4/10/00", ok, nc, req_txe, req_err);
        end
        stop(1);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nc;
        start(0, 1'b0, 64'h50, 32'h0);
        wait_txe(ok, nc);
        stop(0);
        repeat (2) @(posedge clk);
        start(1, 1'b0, 64'h60, 32'h0);
        @(posedge clk);
        #2;
        n_cmp++;
        if (ram_txs !== 1'b1 || grant !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_pre: got txs=%b grant=%b, want 1/10", ram_txs, grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ram_txs !== 1'b0 || grant !== '0 || req_txe !== '0) begin
            n_bad++;
            $display("FAIL midrst_async: got txs=%b grant=%b txe=%b, want 0/00/00", ram_txs, grant, req_txe);
        end
        @(negedge clk);
        req_txs = '0;
        req_re  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_txs = 2'b11;
        req_re  = 2'b11;
        @(posedge clk);
        #2;
        n_cmp++;
        if (grant !== 2'b01) begin
            n_bad++;
            $display("FAIL midrst_ptr: got grant=%b, want 01", grant);
        end
        @(negedge clk);
        req_txs = '0;
        req_re  = '0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        req_txs  = '0;
        req_re   = '0;
        req_we   = '0;
        req_addr = '0;
        req_wd   = '0;
        ram_out  = '0;
        test_reset();
        test_read();
        test_simultaneous();
        test_back_to_back();
        test_write_err();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "global timeout");
    end

endmodule
